// File: rtl/hdma_pkg.sv
// Shared definitions for the VRAM DMA controller:
// register map, scheduler states and block geometry.
package hdma_pkg;

    localparam logic [15:0] A_SRC_HI = 16'hFF51;
    localparam logic [15:0] A_SRC_LO = 16'hFF52;
    localparam logic [15:0] A_DST_HI = 16'hFF53;
    localparam logic [15:0] A_DST_LO = 16'hFF54;
    localparam logic [15:0] A_CTRL   = 16'hFF55;

    localparam int BLOCK_BYTES = 16;

    typedef enum logic [2:0] {
        IDLE,
        GP_RUN,
        HB_WAIT,
        HB_RUN,
        HB_HOLD
    } state_t;

endpackage

// File: rtl/hdma_block.sv
// One 16-byte block mover: alternating read/write phases,
// with the source byte latched at the end of each read phase.
module hdma_block
    import hdma_pkg::*;
#(
    parameter int BYTE_CLKS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [11:0] i_src,
    input  logic [8:0]  i_dst,
    input  logic [7:0]  i_din,
    output logic [15:0] o_a,
    output logic        o_rd,
    output logic        o_wr,
    output logic [7:0]  o_dout,
    output logic        o_occ_ext,
    output logic        o_occ_vid,
    output logic        o_done
);

    localparam int LAST  = BLOCK_BYTES * BYTE_CLKS - 1;
    localparam int CNT_W = $clog2(LAST + 1);

    logic             r_active;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_data;

    logic       w_rph;
    logic       w_wph;
    logic [3:0] w_idx;

    assign w_idx  = r_cnt[CNT_W-1 -: 4];
    assign w_rph  = r_active && !r_cnt[0];
    assign w_wph  = r_active && r_cnt[0];
    assign o_done = w_wph && (r_cnt == CNT_W'(LAST));

    // A start on the done clock chains the next block with no gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_data   <= 8'h00;
        end else begin
            if (i_start) begin
                r_active <= 1'b1;
                r_cnt    <= '0;
            end else if (o_done) begin
                r_active <= 1'b0;
            end else if (r_active) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_rph) begin
                r_data <= i_din;
            end
        end
    end

    always_comb begin
        o_a = 16'h0000;
        if (w_rph) begin
            o_a = {i_src, w_idx};
        end else if (w_wph) begin
            o_a = {3'b100, i_dst, w_idx};
        end
    end

    assign o_rd      = w_rph;
    assign o_wr      = w_wph;
    assign o_dout    = r_data;
    assign o_occ_ext = w_rph;
    assign o_occ_vid = w_wph;

endmodule

// File: rtl/hdma.sv
// VRAM DMA controller: FF51-FF55 register file and the
// general-purpose / HBlank block scheduler.
module hdma
    import hdma_pkg::*;
#(
    parameter int BYTE_CLKS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mmio_a,
    input  logic [7:0]  mmio_din,
    input  logic        mmio_wr,
    output logic [7:0]  mmio_dout,
    input  logic        ppu_hblank,
    output logic [15:0] hdma_a,
    output logic        hdma_rd,
    input  logic [7:0]  hdma_din,
    output logic        hdma_wr,
    output logic [7:0]  hdma_dout,
    output logic        hdma_occupy_extbus,
    output logic        hdma_occupy_vidbus,
    output logic        cpu_stall
);

    state_t      r_state;
    logic [11:0] r_src;
    logic [8:0]  r_dst;
    logic [6:0]  r_len;
    logic        r_term;
    logic        r_hb_prev;

    logic w_wr55;
    logic w_rise;
    logic w_cfg_ok;
    logic w_gp_go;
    logic w_hb_go;
    logic w_gp_next;
    logic w_start;
    logic w_done;

    assign w_wr55    = mmio_wr && (mmio_a == A_CTRL);
    assign w_rise    = ppu_hblank && !r_hb_prev;
    assign w_cfg_ok  = (r_state == IDLE) || (r_state == HB_WAIT)
                    || (r_state == HB_HOLD);
    assign w_gp_go   = (r_state == IDLE) && w_wr55 && !mmio_din[7];
    assign w_hb_go   = (r_state == HB_WAIT) && w_rise && !w_wr55;
    assign w_gp_next = (r_state == GP_RUN) && w_done && (r_len != 7'd0);
    assign w_start   = w_gp_go || w_hb_go || w_gp_next;

    hdma_block #(
        .BYTE_CLKS (BYTE_CLKS)
    ) u_block (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_start),
        .i_src     (r_src),
        .i_dst     (r_dst),
        .i_din     (hdma_din),
        .o_a       (hdma_a),
        .o_rd      (hdma_rd),
        .o_wr      (hdma_wr),
        .o_dout    (hdma_dout),
        .o_occ_ext (hdma_occupy_extbus),
        .o_occ_vid (hdma_occupy_vidbus),
        .o_done    (w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_src     <= 12'h000;
            r_dst     <= 9'h000;
            r_len     <= 7'h7F;
            r_term    <= 1'b0;
            r_hb_prev <= 1'b0;
        end else begin
            r_hb_prev <= ppu_hblank;
            if (w_cfg_ok && mmio_wr) begin
                case (mmio_a)
                    A_SRC_HI: r_src[11:4] <= mmio_din;
                    A_SRC_LO: r_src[3:0]  <= mmio_din[7:4];
                    A_DST_HI: r_dst[8:4]  <= mmio_din[4:0];
                    A_DST_LO: r_dst[3:0]  <= mmio_din[7:4];
                    default: ;
                endcase
            end
            // Pointers wrap naturally within their widths.
            if (w_done) begin
                r_src <= r_src + 12'd1;
                r_dst <= r_dst + 9'd1;
                r_len <= r_len - 7'd1;
            end
            case (r_state)
                IDLE: begin
                    if (w_wr55) begin
                        r_len   <= mmio_din[6:0];
                        r_term  <= 1'b0;
                        r_state <= mmio_din[7] ? HB_WAIT : GP_RUN;
                    end
                end
                GP_RUN: begin
                    if (w_done && (r_len == 7'd0)) begin
                        r_state <= IDLE;
                    end
                end
                HB_WAIT: begin
                    if (w_wr55) begin
                        if (mmio_din[7]) begin
                            r_len <= mmio_din[6:0];
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_rise) begin
                        r_state <= HB_RUN;
                    end
                end
                HB_RUN: begin
                    if (w_wr55) begin
                        r_term <= !mmio_din[7];
                        if (mmio_din[7]) begin
                            r_len <= mmio_din[6:0];
                        end
                    end
                    if (w_done) begin
                        if ((r_len == 7'd0) || r_term
                            || (w_wr55 && !mmio_din[7])) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= HB_HOLD;
                        end
                    end
                end
                HB_HOLD: begin
                    if (w_wr55) begin
                        if (mmio_din[7]) begin
                            r_len   <= mmio_din[6:0];
                            r_state <= HB_WAIT;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (!ppu_hblank) begin
                        r_state <= HB_WAIT;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mmio_dout = 8'hFF;
        if (mmio_a == A_CTRL) begin
            mmio_dout = {(r_state == IDLE), r_len};
        end
    end

    assign cpu_stall = (r_state == GP_RUN) || (r_state == HB_RUN);

endmodule

// File: tb/tb_hdma.sv
// Directed bench for hdma: GP copy, HBlank copy, termination,
// pointer wrap and mid-transfer reset.
module tb_hdma;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mmio_a;
    logic [7:0]  mmio_din;
    logic        mmio_wr;
    logic [7:0]  mmio_dout;
    logic        ppu_hblank;
    logic [15:0] hdma_a;
    logic        hdma_rd;
    logic [7:0]  hdma_din;
    logic        hdma_wr;
    logic [7:0]  hdma_dout;
    logic        occ_ext;
    logic        occ_vid;
    logic        cpu_stall;

    logic [7:0] mem  [65536];
    logic [7:0] vram [8192];

    int n_tot = 0;
    int n_bad = 0;
    int n_rd = 0;
    int n_wr = 0;
    int n_stall = 0;

    always #5 clk = ~clk;

    hdma #(.BYTE_CLKS(2)) dut (
        .clk                (clk),
        .rst                (rst),
        .mmio_a             (mmio_a),
        .mmio_din           (mmio_din),
        .mmio_wr            (mmio_wr),
        .mmio_dout          (mmio_dout),
        .ppu_hblank         (ppu_hblank),
        .hdma_a             (hdma_a),
        .hdma_rd            (hdma_rd),
        .hdma_din           (hdma_din),
        .hdma_wr            (hdma_wr),
        .hdma_dout          (hdma_dout),
        .hdma_occupy_extbus (occ_ext),
        .hdma_occupy_vidbus (occ_vid),
        .cpu_stall          (cpu_stall)
    );

    assign hdma_din = mem[hdma_a];

    always @(posedge clk) begin
        if (hdma_wr) begin
            vram[hdma_a[12:0]] = hdma_dout;
            n_wr++;
        end
        if (hdma_rd) n_rd++;
        if (cpu_stall) n_stall++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wreg(input logic [15:0] a, input logic [7:0] d);
        mmio_a = a;
        mmio_din = d;
        mmio_wr = 1'b1;
        step(1);
        mmio_wr = 1'b0;
    endtask

    task automatic rd55(output logic [7:0] v);
        mmio_a = 16'hFF55;
        #1;
        v = mmio_dout;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (cpu_stall && k < 400) begin
            step(1);
            k++;
        end
        chk(tag, {31'd0, cpu_stall}, 0);
    endtask

    task automatic hb_block(input string tag);
        int s0;
        ppu_hblank = 1'b0;
        step(3);
        ppu_hblank = 1'b1;
        s0 = n_stall;
        step(1);
        chk({tag, "_start"}, {31'd0, cpu_stall & hdma_rd}, 1);
        wait_idle({tag, "_end"});
        chk({tag, "_stall32"}, n_stall - s0, 32);
        step(4);
    endtask

    initial begin
        logic [7:0] v;
        int s0, w0, r0, e;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
        end
        for (int i = 0; i < 8192; i++) vram[i] = 8'h00;
        rst = 1'b1;
        mmio_a = 16'h0000;
        mmio_din = 8'h00;
        mmio_wr = 1'b0;
        ppu_hblank = 1'b0;
        step(3);
        rst = 1'b0;
        chk("rst_rd", {31'd0, hdma_rd}, 0);
        chk("rst_wr", {31'd0, hdma_wr}, 0);
        chk("rst_stall", {31'd0, cpu_stall}, 0);
        chk("rst_a", hdma_a, 16'h0000);
        rd55(v);
        chk("rst_ff55", v, 8'hFF);
        mmio_a = 16'hFF51;
        #1;
        chk("rd_ff51", mmio_dout, 8'hFF);

        // general-purpose, two blocks from C000 to 8000
        wreg(16'hFF51, 8'hC0);
        wreg(16'hFF52, 8'h00);
        wreg(16'hFF53, 8'h00);
        wreg(16'hFF54, 8'h00);
        s0 = n_stall; w0 = n_wr; r0 = n_rd;
        wreg(16'hFF55, 8'h01);
        chk("gp_stall1", {31'd0, cpu_stall}, 1);
        chk("gp_rd1", {31'd0, hdma_rd & occ_ext}, 1);
        chk("gp_a1", hdma_a, 16'hC000);
        step(1);
        chk("gp_wr_a", hdma_a, 16'h8000);
        chk("gp_wr_d", {hdma_wr, occ_vid, hdma_dout}, {2'b11, 8'h9A});
        wait_idle("gp_end");
        chk("gp_stall64", n_stall - s0, 64);
        chk("gp_nwr", n_wr - w0, 32);
        chk("gp_nrd", n_rd - r0, 32);
        e = 0;
        for (int i = 0; i < 32; i++) begin
            if (vram[i] !== mem[16'hC000 + i]) e++;
        end
        chk("gp_data", e, 0);
        rd55(v);
        chk("gp_ff55", v, 8'hFF);

        // HBlank, three blocks continuing at C020 -> 8020
        wreg(16'hFF55, 8'h82);
        rd55(v);
        chk("hb_ff55_0", v, 8'h02);
        w0 = n_wr;
        step(6);
        chk("hb_quiet", n_wr - w0, 0);
        hb_block("hb1");
        chk("hb1_nwr", n_wr - w0, 16);
        rd55(v);
        chk("hb_ff55_1", v, 8'h01);
        hb_block("hb2");
        rd55(v);
        chk("hb_ff55_2", v, 8'h00);
        hb_block("hb3");
        rd55(v);
        chk("hb_ff55_3", v, 8'hFF);
        chk("hb_nwr", n_wr - w0, 48);
        e = 0;
        for (int i = 0; i < 48; i++) begin
            if (vram[16'h0020 + i] !== mem[16'hC020 + i]) e++;
        end
        chk("hb_data", e, 0);

        // terminate in HB_HOLD after block 1 of 4
        wreg(16'hFF55, 8'h83);
        hb_block("tm1");
        rd55(v);
        chk("tm_hold_ff55", v, 8'h02);
        wreg(16'hFF55, 8'h00);
        rd55(v);
        chk("tm_ff55", v, 8'h82);
        w0 = n_wr;
        ppu_hblank = 1'b0;
        step(3);
        ppu_hblank = 1'b1;
        step(10);
        chk("tm_nowr", n_wr - w0, 0);
        chk("tm_nostall", {31'd0, cpu_stall}, 0);

        // terminate mid-block
        wreg(16'hFF55, 8'h81);
        ppu_hblank = 1'b0;
        step(3);
        ppu_hblank = 1'b1;
        w0 = n_wr; s0 = n_stall;
        step(6);
        wreg(16'hFF55, 8'h00);
        wait_idle("tmr_end");
        chk("tmr_nwr", n_wr - w0, 16);
        chk("tmr_stall", n_stall - s0, 32);
        rd55(v);
        chk("tmr_ff55", v, 8'h80);
        e = 0;
        for (int i = 0; i < 16; i++) begin
            if (vram[16'h0060 + i] !== mem[16'hC060 + i]) e++;
        end
        chk("tmr_data", e, 0);

        // wrap of both pointers
        wreg(16'hFF51, 8'hFF);
        wreg(16'hFF52, 8'hF0);
        wreg(16'hFF53, 8'h1F);
        wreg(16'hFF54, 8'hF0);
        wreg(16'hFF55, 8'h01);
        step(32);
        chk("wr_a2", hdma_a, 16'h0000);
        wait_idle("wr_end");
        e = 0;
        for (int i = 0; i < 16; i++) begin
            if (vram[16'h1FF0 + i] !== mem[16'hFFF0 + i]) e++;
            if (vram[i] !== mem[i]) e++;
        end
        chk("wr_data", e, 0);

        // reset during byte 5 of a GP transfer
        wreg(16'hFF51, 8'hC0);
        wreg(16'hFF52, 8'h00);
        wreg(16'hFF55, 8'h03);
        step(10);
        chk("rs_busy", {31'd0, hdma_rd & cpu_stall}, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rs_strobes", {28'd0, hdma_rd, hdma_wr, occ_ext, occ_vid}, 0);
        chk("rs_stall", {31'd0, cpu_stall}, 0);
        chk("rs_a", hdma_a, 16'h0000);
        chk("rs_dout", hdma_dout, 8'h00);
        rd55(v);
        chk("rs_ff55", v, 8'hFF);
        w0 = n_wr;
        step(5);
        chk("rs_quiet", n_wr - w0, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
